// File: rtl/bp_mac_ctrl.sv
// Backprop MAC sequencer: per output row, clear the MAC, stream 4 gates x N_IN
// (dgate, weight) pairs, then write the accumulated result to dX or dOut.
module bp_mac_ctrl #(
   parameter int N_OUT   = 53,
   parameter int N_IN    = 8,
   parameter int WADDR_W = 9,
   parameter int DADDR_W = 6,
   parameter int OADDR_W = 9,
   parameter int RD_LAT  = 1,
   parameter int MAC_LAT = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               mode,
   output logic               busy,
   output logic               done,
   output logic [1:0]         sel_dgate,
   output logic [2:0]         sel_wghts2,
   output logic [WADDR_W-1:0] wght_addr,
   output logic [DADDR_W-1:0] dg_addr,
   output logic               rst_mac,
   output logic               acc_mac,
   output logic               wr_dx2,
   output logic               wr_dout2,
   output logic [OADDR_W-1:0] wr_addr
);

   localparam int K_W   = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int D_LEN = RD_LAT + MAC_LAT;
   localparam int D_W   = (D_LEN > 1) ? $clog2(D_LEN) : 1;

   typedef enum logic [2:0] {
      ST_IDLE, ST_CLR, ST_RUN, ST_DRAIN, ST_WRITE, ST_DONE
   } state_t;

   state_t             state_reg;
   logic               mode_reg;
   logic [OADDR_W-1:0] n_reg;
   logic [WADDR_W-1:0] base_reg;
   logic [1:0]         g_reg;
   logic [K_W-1:0]     k_reg;
   logic [D_W-1:0]     drain_reg;
   logic               issue_vld_reg;
   logic [1:0]         issue_gate_reg;

   // g_reg/k_reg name the operand pair currently presented on the address outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         mode_reg       <= 1'b0;
         n_reg          <= '0;
         base_reg       <= '0;
         g_reg          <= '0;
         k_reg          <= '0;
         drain_reg      <= '0;
         issue_vld_reg  <= 1'b0;
         issue_gate_reg <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         rst_mac        <= 1'b0;
         wght_addr      <= '0;
         dg_addr        <= '0;
         wr_dx2         <= 1'b0;
         wr_dout2       <= 1'b0;
         wr_addr        <= '0;
      end else begin
         rst_mac        <= 1'b0;
         done           <= 1'b0;
         issue_vld_reg  <= 1'b0;
         issue_gate_reg <= '0;
         wght_addr      <= '0;
         dg_addr        <= '0;
         wr_dx2         <= 1'b0;
         wr_dout2       <= 1'b0;
         wr_addr        <= '0;
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  mode_reg  <= mode;
                  n_reg     <= '0;
                  base_reg  <= '0;
                  g_reg     <= '0;
                  k_reg     <= '0;
                  busy      <= 1'b1;
                  rst_mac   <= 1'b1;
                  state_reg <= ST_CLR;
               end
            end
            ST_CLR: begin
               issue_vld_reg  <= 1'b1;
               issue_gate_reg <= g_reg;
               wght_addr      <= base_reg;
               dg_addr        <= '0;
               state_reg      <= ST_RUN;
            end
            ST_RUN: begin
               if (g_reg == 2'd3 && k_reg == K_W'(N_IN - 1)) begin
                  drain_reg <= '0;
                  state_reg <= ST_DRAIN;
               end else if (k_reg == K_W'(N_IN - 1)) begin
                  k_reg          <= '0;
                  g_reg          <= g_reg + 2'd1;
                  issue_vld_reg  <= 1'b1;
                  issue_gate_reg <= g_reg + 2'd1;
                  wght_addr      <= base_reg;
                  dg_addr        <= '0;
               end else begin
                  k_reg          <= k_reg + K_W'(1);
                  issue_vld_reg  <= 1'b1;
                  issue_gate_reg <= g_reg;
                  wght_addr      <= base_reg + WADDR_W'(k_reg) + WADDR_W'(1);
                  dg_addr        <= DADDR_W'(k_reg) + DADDR_W'(1);
               end
            end
            ST_DRAIN: begin
               if (drain_reg == D_W'(D_LEN - 1)) begin
                  wr_addr   <= n_reg;
                  wr_dx2    <= ~mode_reg;
                  wr_dout2  <= mode_reg;
                  state_reg <= ST_WRITE;
               end else begin
                  drain_reg <= drain_reg + D_W'(1);
               end
            end
            ST_WRITE: begin
               if (n_reg == OADDR_W'(N_OUT - 1)) begin
                  done      <= 1'b1;
                  state_reg <= ST_DONE;
               end else begin
                  n_reg     <= n_reg + OADDR_W'(1);
                  base_reg  <= base_reg + WADDR_W'(N_IN);
                  g_reg     <= '0;
                  k_reg     <= '0;
                  rst_mac   <= 1'b1;
                  state_reg <= ST_CLR;
               end
            end
            ST_DONE: begin
               busy      <= 1'b0;
               state_reg <= ST_IDLE;
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Delay the issue flag and gate by the read latency so they meet the operands.
   logic [RD_LAT-1:0] vld_pipe_reg;
   logic [RD_LAT-1:0] vld_pipe_next;
   logic [1:0]        gate_pipe_reg  [RD_LAT];
   logic [1:0]        gate_pipe_next [RD_LAT];

   assign vld_pipe_next[0]  = issue_vld_reg;
   assign gate_pipe_next[0] = issue_gate_reg;

   generate
      for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_pipe
         assign vld_pipe_next[gi]  = vld_pipe_reg[gi-1];
         assign gate_pipe_next[gi] = gate_pipe_reg[gi-1];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe_reg <= '0;
         for (int i = 0; i < RD_LAT; i++) gate_pipe_reg[i] <= '0;
      end else begin
         vld_pipe_reg <= vld_pipe_next;
         for (int i = 0; i < RD_LAT; i++) gate_pipe_reg[i] <= gate_pipe_next[i];
      end
   end

   assign acc_mac    = vld_pipe_reg[RD_LAT-1];
   assign sel_dgate  = gate_pipe_reg[RD_LAT-1];
   assign sel_wghts2 = {mode_reg & busy, gate_pipe_reg[RD_LAT-1]};

endmodule

// File: tb/tb_bp_mac_ctrl.sv
// Bench for bp_mac_ctrl: two instances (53 and 8 outputs) checked every cycle
// against a timeline computed from the run period, plus a unit-operand MAC scoreboard.
module tb_bp_mac_ctrl;

   localparam int N_IN   = 8;
   localparam int RD_LAT = 1;
   localparam int MAC_LAT = 1;
   localparam int P      = 2 + 4*N_IN + RD_LAT + MAC_LAT;
   localparam int NA     = 53;
   localparam int NB     = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start_a = 1'b0, mode_a = 1'b0, start_b = 1'b0, mode_b = 1'b0;

   logic       busy_a, done_a, rst_mac_a, acc_mac_a, wr_dx2_a, wr_dout2_a;
   logic [1:0] sel_dgate_a;
   logic [2:0] sel_wghts2_a;
   logic [8:0] wght_addr_a, wr_addr_a;
   logic [5:0] dg_addr_a;

   logic       busy_b, done_b, rst_mac_b, acc_mac_b, wr_dx2_b, wr_dout2_b;
   logic [1:0] sel_dgate_b;
   logic [2:0] sel_wghts2_b;
   logic [8:0] wght_addr_b, wr_addr_b;
   logic [5:0] dg_addr_b;

   always #5 clk = ~clk;

   bp_mac_ctrl #(.N_OUT(NA), .N_IN(N_IN)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .mode(mode_a),
      .busy(busy_a), .done(done_a), .sel_dgate(sel_dgate_a), .sel_wghts2(sel_wghts2_a),
      .wght_addr(wght_addr_a), .dg_addr(dg_addr_a), .rst_mac(rst_mac_a), .acc_mac(acc_mac_a),
      .wr_dx2(wr_dx2_a), .wr_dout2(wr_dout2_a), .wr_addr(wr_addr_a)
   );

   bp_mac_ctrl #(.N_OUT(NB), .N_IN(N_IN)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .mode(mode_b),
      .busy(busy_b), .done(done_b), .sel_dgate(sel_dgate_b), .sel_wghts2(sel_wghts2_b),
      .wght_addr(wght_addr_b), .dg_addr(dg_addr_b), .rst_mac(rst_mac_b), .acc_mac(acc_mac_b),
      .wr_dx2(wr_dx2_b), .wr_dout2(wr_dout2_b), .wr_addr(wr_addr_b)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Reference state: a run is a timeline of cycles t = 1 .. P*N_OUT+1 after the accepted start.
   bit act_a = 0, md_a = 0, act_b = 0, md_b = 0;
   int t_a = 0, t_b = 0;
   int mac_a = 0, mac_b = 0;
   int wr_cnt_a = 0, wr_cnt_b = 0, done_cnt_a = 0, done_cnt_b = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ctrl = {busy,done,rst_mac,acc_mac,wr_dx2,wr_dout2}; addr = {wght,dg,wr}; sel = {sel_dgate,sel_wghts2}
   task automatic expect_out(input int nout, input bit act, input int t, input bit md,
                             output logic [5:0] c, output logic [23:0] a, output logic [4:0] s);
      int r, n, k, rr;
      c = '0; a = '0; s = '0;
      if (act) begin
         c[5] = 1'b1;
         s[2] = md;
         if (t == P*nout + 1) c[4] = 1'b1;
         if (t <= P*nout) begin
            r = (t - 1) % P;
            n = (t - 1) / P;
            if (r == 0) c[3] = 1'b1;
            if (r >= 1 && r <= 4*N_IN) begin
               k = (r - 1) % N_IN;
               a[23:15] = 9'(n*N_IN + k);
               a[14:9]  = 6'(k);
            end
            rr = r - RD_LAT;
            if (rr >= 1 && rr <= 4*N_IN) begin
               c[2]   = 1'b1;
               s[4:3] = 2'((rr - 1) / N_IN);
               s[1:0] = 2'((rr - 1) / N_IN);
            end
            if (r == P - 1) begin
               c[1]   = ~md;
               c[0]   = md;
               a[8:0] = 9'(n);
            end
         end
      end
   endtask

   task automatic step();
      bit sa, sb, r;
      logic [5:0]  c;
      logic [23:0] a;
      logic [4:0]  s;
      sa = start_a; sb = start_b; r = rst;
      @(posedge clk);
      if (r) act_a = 0;
      else if (act_a) begin t_a++; if (t_a == P*NA + 2) act_a = 0; end
      else if (sa) begin act_a = 1; t_a = 1; md_a = mode_a; end
      if (r) act_b = 0;
      else if (act_b) begin t_b++; if (t_b == P*NB + 2) act_b = 0; end
      else if (sb) begin act_b = 1; t_b = 1; md_b = mode_b; end
      #1;
      expect_out(NA, act_a, t_a, md_a, c, a, s);
      chk("a_ctrl", {26'b0, busy_a, done_a, rst_mac_a, acc_mac_a, wr_dx2_a, wr_dout2_a}, {26'b0, c});
      chk("a_addr", {8'b0, wght_addr_a, dg_addr_a, wr_addr_a}, {8'b0, a});
      chk("a_sel", {27'b0, sel_dgate_a, sel_wghts2_a}, {27'b0, s});
      expect_out(NB, act_b, t_b, md_b, c, a, s);
      chk("b_ctrl", {26'b0, busy_b, done_b, rst_mac_b, acc_mac_b, wr_dx2_b, wr_dout2_b}, {26'b0, c});
      chk("b_addr", {8'b0, wght_addr_b, dg_addr_b, wr_addr_b}, {8'b0, a});
      chk("b_sel", {27'b0, sel_dgate_b, sel_wghts2_b}, {27'b0, s});
      // MAC with weight = dgate = 1: each written result is the number of accumulate cycles.
      if (rst_mac_a) mac_a = 0;
      if (acc_mac_a) mac_a++;
      if (wr_dx2_a || wr_dout2_a) begin wr_cnt_a++; chk("a_mac_value", mac_a, 4*N_IN); end
      if (done_a) done_cnt_a++;
      if (rst_mac_b) mac_b = 0;
      if (acc_mac_b) mac_b++;
      if (wr_dx2_b || wr_dout2_b) begin wr_cnt_b++; chk("b_mac_value", mac_b, 4*N_IN); end
      if (done_b) done_cnt_b++;
   endtask

   task automatic clear_counts();
      wr_cnt_a = 0; wr_cnt_b = 0; done_cnt_a = 0; done_cnt_b = 0;
   endtask

   // Step until both instances are idle; optional stray starts must all be ignored.
   task automatic run_to_idle(input bit stray);
      for (int i = 0; i < 2500 && (act_a || act_b); i++) begin
         start_a = stray && act_a && (t_a == 5 || t_a == 500 || t_a == P*NA + 1);
         start_b = stray && act_b && ($urandom_range(0, 7) == 0);
         mode_a  = 1'($urandom);
         mode_b  = 1'($urandom);
         step();
      end
      start_a = 1'b0;
      start_b = 1'b0;
      chk("a_idle_after_run", {31'b0, busy_a}, 32'd0);
      chk("b_idle_after_run", {31'b0, busy_b}, 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      step();

      // Run 1: A in mode 0 with stray starts, B in mode 1 (8 outputs).
      clear_counts();
      mode_a = 1'b0; mode_b = 1'b1; start_a = 1'b1; start_b = 1'b1;
      step();
      start_a = 1'b0; start_b = 1'b0;
      run_to_idle(1'b1);
      chk("a_run1_writes", wr_cnt_a, NA);
      chk("a_run1_dones", done_cnt_a, 1);
      chk("b_run1_writes", wr_cnt_b, NB);
      chk("b_run1_dones", done_cnt_b, 1);

      // Run 2: reset A at cycle 100, then restart.
      clear_counts();
      mode_a = 1'($urandom); start_a = 1'b1;
      step();
      start_a = 1'b0;
      for (int i = 0; i < 200 && t_a < 100; i++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("a_rst_all_zero", {26'b0, busy_a, done_a, rst_mac_a, acc_mac_a, wr_dx2_a, wr_dout2_a}, 32'd0);
      repeat ($urandom_range(1, 10)) step();
      chk("a_rst_writes", wr_cnt_a, 2);
      chk("a_rst_dones", done_cnt_a, 0);
      clear_counts();
      mode_a = 1'($urandom); start_a = 1'b1;
      step();
      start_a = 1'b0;
      run_to_idle(1'b0);
      chk("a_run2_writes", wr_cnt_a, NA);
      chk("a_run2_dones", done_cnt_a, 1);

      // Run 3: random modes, random idle gap, B started late with stray starts.
      clear_counts();
      mode_a = 1'($urandom); start_a = 1'b1;
      step();
      start_a = 1'b0;
      repeat ($urandom_range(0, 40)) step();
      mode_b = 1'($urandom); start_b = 1'b1;
      step();
      start_b = 1'b0;
      run_to_idle(1'b1);
      chk("a_run3_writes", wr_cnt_a, NA);
      chk("b_run3_writes", wr_cnt_b, NB);
      chk("b_run3_dones", done_cnt_b, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/bp_mac_ctrl.md
# bp_mac_ctrl

Sequencer for the backpropagation MAC path that computes layer-2 dX (mode 0, W weights) or recurrent delta-out (mode 1, U weights).
- For each output element n it clears the MAC, streams 4 gates × N_IN cells of (dgate, weight) operand pairs, then issues one write to the dX or dOut memory.
- It drives the dgate mux select, the weight mux select, the weight/dgate read addresses, the MAC control (rst_mac, acc_mac) and the result memory write strobes.

## Interface
Parameters:
- N_OUT, 53, output elements per run (dX rows / dOut entries)
- N_IN, 8, layer-2 cells per gate (inner loop length)
- WADDR_W, 9, weight address width; must satisfy 2^WADDR_W ≥ N_OUT·N_IN
- DADDR_W, 6, dgate read address width
- OADDR_W, 9, result write address width
- RD_LAT, 1, cycles from address issue to operand valid at MAC input
- MAC_LAT, 1, cycles from last acc_mac to valid o_mac

Ports:
- clk  in  1  clock; all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a run; sampled only in IDLE
- mode  in  1  0 = dX (W weights, wr_dx2); 1 = dOut (U weights, wr_dout2); latched at start
- busy  out  1  high from cycle after accepted start until DONE inclusive
- done  out  1  one-cycle pulse at end of run
- sel_dgate  out  2  gate select to dgate mux (0 a, 1 i, 2 f, 3 o), aligned to operand
- sel_wghts2  out  3  [1:0] gate, [2] = latched mode; aligned to operand
- wght_addr  out  WADDR_W  weight read address = n·N_IN + k
- dg_addr  out  DADDR_W  dgate read address = k
- rst_mac  out  1  MAC clear pulse
- acc_mac  out  1  MAC accumulate enable
- wr_dx2  out  1  dX memory write strobe
- wr_dout2  out  1  dOut memory write strobe
- wr_addr  out  OADDR_W  result write address = n

## Operation
- Counters:
  - n: 0..N_OUT-1
  - g: 0..3
  - k: 0..N_IN-1
  - Row base register: tracks n·N_IN by adding N_IN per output; no multiplier.
- FSM states: IDLE, CLR, RUN, DRAIN, WRITE, DONE.
  - IDLE: all outputs 0. start=1 → latch mode, clear n/g/k/base → CLR.
  - CLR (1 cycle): rst_mac=1 → RUN.
  - RUN (exactly 4·N_IN cycles): issue wght_addr = base+k and dg_addr = k. Loop order is g outer, k inner. On g=3, k=N_IN-1 → DRAIN.
  - DRAIN (RD_LAT+MAC_LAT cycles) → WRITE.
  - WRITE (1 cycle): wr_dx2 (mode 0) or wr_dout2 (mode 1) = 1, wr_addr = n.
    - If n = N_OUT-1 → DONE.
    - Otherwise n++, base += N_IN → CLR.
  - DONE (1 cycle): done=1 → IDLE.
- Operand alignment: the RUN-issue valid flag and gate index pass through an RD_LAT-deep shift register. Its outputs drive acc_mac and sel_dgate / sel_wghts2[1:0]. acc_mac is high for exactly 4·N_IN cycles per output, with no gaps.
- Idle values: sel_wghts2[2] holds latched mode throughout a run. Outside RUN/pipeline, wght_addr, dg_addr and sel_dgate hold 0.
- Only one write strobe is ever high; never both.

## Timing
- Reset: every output is 0 the cycle after rst=1. FSM → IDLE, pipeline flags cleared, latched mode = 0.
- rst mid-run: abort immediately, no write, no done.
- start in cycle 0 (IDLE) gives:
  - cycle 1: CLR
  - cycles 2..4·N_IN+1: RUN
  - first acc_mac at cycle 2+RD_LAT
- Period per output: P = 2 + 4·N_IN + RD_LAT + MAC_LAT.
  - WRITE for output n occurs at cycle P·(n+1).
  - done is high at cycle P·N_OUT + 1.
- start while busy is ignored. start coincident with DONE is ignored; it is accepted only when seen in IDLE.
- The rst_mac pulse never overlaps acc_mac.
- The previous output's WRITE precedes the next CLR by one cycle.

## Test plan
- Defaults, mode 0, start at cycle 0:
  - done at cycle 1909 (P=36).
  - 53 wr_dx2 pulses with wr_addr 0..52 at cycles 36, 72, …, 1908.
  - wr_dout2 never high.
- Mode 1 with N_OUT=8, N_IN=8:
  - sel_wghts2[2]=1 for the whole run.
  - 8 wr_dout2 pulses, addr 0..7.
  - done at cycle 289.
- Address sequence check, n=2 with N_IN=8:
  - wght_addr cycles 16..23 four times.
  - sel_dgate steps 0,1,2,3, delayed RD_LAT cycles from address.
  - acc_mac count per output = 32.
- start pulsed at cycles 5 and 500 during a run and at the DONE cycle: ignored; exactly one done pulse.
- rst asserted at cycle 100 of a run: all outputs 0 next cycle, no further writes. A new start then completes normally with wr_addr starting at 0.
- Scoreboard with a MAC model using constant weights=1 and dgate=1: each written value = 4·N_IN.
